muldiv_wb_unit: RTL and testbench
=================================

Name: muldiv_wb_unit

Overview:
- Iterative multi-cycle multiply/divide execution unit.
- Sits between operand read and register write.
- Consumes the two 16-bit source operands and a 3-bit destination register index.
- Produces a single-cycle write request (wr_en / wr_reg / wr_data) that drives the register file write port directly.

Parameters:
- WIDTH, 16, operand/result width; iteration count equals WIDTH.
- REG_ADDR_W, 3, destination register index width (8 registers).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- op  input  2  00=MUL (low half), 01=MULH (high half), 10=DIV (quotient), 11=REM (remainder).
- operand_a  input  WIDTH  multiplicand / dividend.
- operand_b  input  WIDTH  multiplier / divisor.
- dest_reg  input  REG_ADDR_W  destination register index.
- busy  output  1  high from the cycle after accept through the WB cycle inclusive.
- done  output  1  one-cycle completion pulse.
- wr_en  output  1  register-file write enable, one cycle.
- wr_reg  output  REG_ADDR_W  write index, valid when wr_en=1.
- wr_data  output  WIDTH  write data, valid when done=1.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is synchronous, active-low.
- Reset values: state=IDLE; busy, done, wr_en = 0; wr_reg = 0; wr_data = 0. Internal accumulator, shift and count registers = 0.
- IDLE state:
  - If start=1: latch op, operand_a, operand_b and dest_reg; clear the counter; go to RUN.
  - Otherwise stay in IDLE.
- RUN state: one iteration per clock for WIDTH cycles; count runs 0..WIDTH-1. Exit to WB when count==WIDTH-1.
  - MUL/MULH: shift-add. A 2*WIDTH product register is built LSB-first from operand_b bits. The adder is WIDTH+1 bits so the carry is kept.
  - DIV/REM: restoring division. The remainder register is WIDTH+1 bits; shift in the dividend MSB-first and trial-subtract the divisor. Quotient bit = 1 when the result is non-negative.
- WB state (exactly one cycle): done=1; wr_data = selected result; go to IDLE.
  - wr_en=1 and wr_reg=dest_reg, except when dest_reg==0: then wr_en=0 because register 0 is hardwired to zero. done still pulses.
- Latency: start accepted in cycle T; RUN occupies T+1..T+WIDTH; done/wr_en are high in cycle T+WIDTH+1. Fixed latency of 17 cycles at WIDTH=16, for every op and operand value.
- Back-to-back: the next start is accepted no earlier than the cycle after WB. Minimum issue interval is WIDTH+2 cycles.
- Start while busy: ignored with no effect. Latched operands are unaffected by input changes after accept.
- Divide by zero (operand_b==0): still full latency. DIV returns all-ones (16'hFFFF); REM returns operand_a.
- MUL/MULH results: MUL = product[WIDTH-1:0]; MULH = product[2*WIDTH-1:WIDTH]. Unsigned unless the optional feature is enabled.
- Output hold: done, wr_en and wr_reg deassert and return to 0 in the cycle after WB. wr_data holds its last value until the next WB.
- Reset mid-operation: rst_n=0 in any RUN cycle aborts the operation. The unit is in IDLE the next cycle, with no done and no wr_en ever produced for the aborted op.
- start asserted during the same cycle as rst_n=0: reset wins; the request is dropped.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined: operands are treated as two's complement.
  - Magnitudes are computed at accept, the unsigned core runs, and the result sign is fixed in WB. Latency is unchanged.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - MULH returns the signed high half.
  - Overflow case 16'h8000 / 16'hFFFF gives DIV=16'h8000, REM=16'h0000.
  - Divide by zero: DIV=16'hFFFF, REM=operand_a.
- Not defined: all ops are unsigned, as described above, and no sign logic is generated.

Test Plan:
- MUL 300*500 (0x012C*0x01F4), dest=3 -> cycle T+17: done=1, wr_en=1, wr_reg=3, wr_data=0x49F0. Repeated as MULH -> wr_data=0x0002.
- DIV 1000/7, dest=5 -> wr_data=0x008E. REM 1000/7 -> wr_data=0x0006. busy high exactly cycles T+1..T+17.
- DIV 0x1234/0 -> wr_data=0xFFFF. REM 0x1234/0 -> wr_data=0x1234. Latency is still 17 cycles.
- start re-pulsed at T+5 with different operands during MUL 3*4 -> a single done at T+17 with wr_data=0x000C and no second done.
- rst_n=0 for one cycle at T+8 of DIV 100/3 -> busy=0 at T+9; no done or wr_en through T+40. A fresh MUL 2*2 issued afterwards returns 0x0004.
- MUL 5*5 with dest_reg=0 -> done=1, wr_en=0, wr_data=0x0019. With MULDIV_SIGNED_EN: DIV 0xFFF9/0x0002 -> 0xFFFD, REM -> 0xFFFF.

Source files
------------

// File: rtl/muldiv_wb_if.sv
// ============================================================================
// Module      : muldiv_wb_if
// Description : Request and write-back bundle between the operand-read stage,
//               the iterative multiply/divide unit and the register-file
//               write port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface muldiv_wb_if #(
  parameter int WIDTH      = 16,
  parameter int REG_ADDR_W = 3
);
  // Request side
  logic                  start;
  logic [1:0]            op;
  logic [WIDTH-1:0]      operand_a;
  logic [WIDTH-1:0]      operand_b;
  logic [REG_ADDR_W-1:0] dest_reg;

  // Status and write-back side
  logic                  busy;
  logic                  done;
  logic                  wr_en;
  logic [REG_ADDR_W-1:0] wr_reg;
  logic [WIDTH-1:0]      wr_data;

  // Issuing stage: drives requests, observes status and write-back
  modport master (
    output start, op, operand_a, operand_b, dest_reg,
    input  busy, done, wr_en, wr_reg, wr_data
  );

  // Execution unit: accepts requests, produces status and write-back
  modport slave (
    input  start, op, operand_a, operand_b, dest_reg,
    output busy, done, wr_en, wr_reg, wr_data
  );
endinterface

`default_nettype wire

// File: rtl/muldiv_wb_unit.sv
// ============================================================================
// Module      : muldiv_wb_unit
// Description : Iterative shift-add multiplier / restoring divider with a
//               single-cycle register-file write-back. Fixed latency of
//               WIDTH+1 cycles from accept to write-back for every op.
//               Optional macro MULDIV_SIGNED_EN: two's complement operands
//               (magnitudes at accept, sign fix-up at the end of RUN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_wb_unit #(
  parameter int WIDTH      = 16,
  parameter int REG_ADDR_W = 3
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  muldiv_wb_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_REM  = 2'b11;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]            state_q,   state_d;
  logic [CNT_W-1:0]      count_q,   count_d;
  logic [1:0]            op_q,      op_d;
  logic [REG_ADDR_W-1:0] dest_q,    dest_d;
  logic [WIDTH-1:0]      opa_q,     opa_d;     // multiplicand (mul path)
  logic [WIDTH-1:0]      opb_q,     opb_d;     // divisor (div path)
  logic [2*WIDTH-1:0]    prod_q,    prod_d;    // product, or dividend/quotient in low half
  logic [WIDTH:0]        rem_q,     rem_d;     // partial remainder
  logic                  done_q,    done_d;
  logic                  wr_en_q,   wr_en_d;
  logic [REG_ADDR_W-1:0] wr_reg_q,  wr_reg_d;
  logic [WIDTH-1:0]      wr_data_q, wr_data_d;

`ifdef MULDIV_SIGNED_EN
  logic                  neg_res_q, neg_res_d;   // product / quotient is negative
  logic                  neg_rem_q, neg_rem_d;   // remainder follows dividend sign
  logic [WIDTH-1:0]      a_orig_q,  a_orig_d;    // raw dividend for divide-by-zero REM
`endif

  // --------------------------------------------------------------------------
  // Datapath wires
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]      w_mag_a;
  logic [WIDTH-1:0]      w_mag_b;
  logic [WIDTH:0]        w_sum;
  logic [2*WIDTH-1:0]    w_prod_step;
  logic [WIDTH:0]        w_shift;
  logic [WIDTH+1:0]      w_diff;
  logic                  w_q_bit;
  logic [WIDTH:0]        w_rem_step;
  logic [WIDTH-1:0]      w_quo_step;
  logic [2*WIDTH-1:0]    w_prod_fin;
  logic [WIDTH-1:0]      w_quo_fin;
  logic [WIDTH-1:0]      w_rem_fin;
  logic [WIDTH-1:0]      w_result;
  logic                  w_last;
  logic                  w_unused;

  // Operand magnitudes captured at accept; identity in the unsigned build
  always_comb begin
    w_mag_a = bus.operand_a;
    w_mag_b = bus.operand_b;
`ifdef MULDIV_SIGNED_EN
    if (bus.operand_a[WIDTH-1]) w_mag_a = -bus.operand_a;
    if (bus.operand_b[WIDTH-1]) w_mag_b = -bus.operand_b;
`endif
  end

  // One shift-add step and one restoring-division step, evaluated every cycle
  always_comb begin
    // Multiply: add multiplicand into the upper half when the current
    // multiplier bit (LSB) is set, keeping the carry, then shift right.
    w_sum       = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, opa_q};
    w_prod_step = prod_q[0] ? {w_sum, prod_q[WIDTH-1:1]}
                            : {1'b0, prod_q[2*WIDTH-1:1]};
    // Divide: shift the next dividend bit into the remainder, trial subtract.
    w_shift     = {rem_q[WIDTH-1:0], prod_q[WIDTH-1]};
    w_diff      = {1'b0, w_shift} - {2'b00, opb_q};
    w_q_bit     = ~w_diff[WIDTH+1];
    w_rem_step  = w_q_bit ? w_diff[WIDTH:0] : w_shift;
    w_quo_step  = {prod_q[WIDTH-2:0], w_q_bit};
  end

  // Final result selection from the last iteration, with sign fix-up if enabled
  always_comb begin
    w_prod_fin = w_prod_step;
    w_quo_fin  = w_quo_step;
    w_rem_fin  = w_rem_step[WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
    if (neg_res_q) begin
      w_prod_fin = -w_prod_step;
      w_quo_fin  = -w_quo_step;
    end
    if (neg_rem_q) w_rem_fin = -w_rem_step[WIDTH-1:0];
    // Divide by zero reports all-ones and the untouched dividend
    if (opb_q == '0) begin
      w_quo_fin = '1;
      w_rem_fin = a_orig_q;
    end
`endif
    case (op_q)
      OP_MUL:  w_result = w_prod_fin[WIDTH-1:0];
      OP_MULH: w_result = w_prod_fin[2*WIDTH-1:WIDTH];
      OP_DIV:  w_result = w_quo_fin;
      OP_REM:  w_result = w_rem_fin;
      default: w_result = '0;
    endcase
  end

  // The partial remainder is always below the divisor, so its top bit only
  // matters inside the trial subtract.
  assign w_unused = &{1'b0, rem_q[WIDTH]};

  assign w_last = (count_q == CNT_W'(WIDTH - 1));

  // Control FSM: accept in IDLE, iterate in RUN, single write-back cycle
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    op_d      = op_q;
    dest_d    = dest_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    prod_d    = prod_q;
    rem_d     = rem_q;
    done_d    = 1'b0;
    wr_en_d   = 1'b0;
    wr_reg_d  = '0;
    wr_data_d = wr_data_q;
`ifdef MULDIV_SIGNED_EN
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    a_orig_d  = a_orig_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          dest_d  = bus.dest_reg;
          opa_d   = w_mag_a;
          opb_d   = w_mag_b;
          count_d = '0;
          rem_d   = '0;
          // Multiplier bits for MUL/MULH, dividend bits for DIV/REM
          prod_d  = bus.op[1] ? {{WIDTH{1'b0}}, w_mag_a} : {{WIDTH{1'b0}}, w_mag_b};
`ifdef MULDIV_SIGNED_EN
          neg_res_d = bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1];
          neg_rem_d = bus.operand_a[WIDTH-1];
          a_orig_d  = bus.operand_a;
`endif
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        count_d = count_q + 1'b1;
        if (op_q[1]) begin
          prod_d = {prod_q[2*WIDTH-1:WIDTH], w_quo_step};
          rem_d  = w_rem_step;
        end else begin
          prod_d = w_prod_step;
        end
        if (w_last) begin
          // Register 0 is hardwired to zero: complete without writing it
          state_d   = S_WB;
          done_d    = 1'b1;
          wr_en_d   = (dest_q != '0);
          wr_reg_d  = dest_q;
          wr_data_d = w_result;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      op_q      <= '0;
      dest_q    <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      prod_q    <= '0;
      rem_q     <= '0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      a_orig_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      op_q      <= op_d;
      dest_q    <= dest_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      prod_q    <= prod_d;
      rem_q     <= rem_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
`ifdef MULDIV_SIGNED_EN
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      a_orig_q  <= a_orig_d;
`endif
    end
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = done_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_reg  = wr_reg_q;
  assign bus.wr_data = wr_data_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_wb_unit.sv
// ============================================================================
// Module      : tb_muldiv_wb_unit
// Description : Scoreboard bench for muldiv_wb_unit: directed cases plus
//               randomized ops checked against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_wb_unit;

  localparam int WIDTH      = 16;
  localparam int REG_ADDR_W = 3;
  localparam int LAT        = WIDTH + 1;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_REM  = 2'b11;

  typedef struct {
    logic [WIDTH-1:0]      data;
    logic                  en;
    logic [REG_ADDR_W-1:0] rg;
    int                    due;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  exp_t             sb_q[$];
  int               acc_cycle = -1;
  logic [WIDTH-1:0] last_data = '0;
  exp_t             mon_e;
  logic             exp_busy;

  muldiv_wb_if #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W)) bus ();

  muldiv_wb_unit #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain arithmetic on the operand values
  function automatic logic [WIDTH-1:0] ref_model(input logic [1:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
`ifdef MULDIV_SIGNED_EN
    longint x = $signed(a);
    longint y = $signed(b);
`else
    longint x = a;
    longint y = b;
`endif
    longint p = x * y;
    case (op)
      OP_MUL:  return p[WIDTH-1:0];
      OP_MULH: return p[2*WIDTH-1:WIDTH];
      OP_DIV:  return (b == 0) ? {WIDTH{1'b1}} : WIDTH'(x / y);
      default: return (b == 0) ? a : WIDTH'(x % y);
    endcase
  endfunction

  // Issue one request once the unit is idle and record the expected write-back
  task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [REG_ADDR_W-1:0] d,
                       input logic [WIDTH-1:0] exp_data);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: busy stuck at 0x%0h expected 0x0", bus.busy);
    end
    bus.start     = 1'b1;
    bus.op        = op;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.dest_reg  = d;
    sb_q.push_back('{data: exp_data, en: (d != 0), rg: d, due: cyc + LAT});
    acc_cycle = cyc;
    @(posedge clk); #1;
    // Scramble inputs after accept: the latched operands must not follow
    bus.start     = 1'b0;
    bus.op        = 2'($urandom);
    bus.operand_a = WIDTH'($urandom);
    bus.operand_b = WIDTH'($urandom);
    bus.dest_reg  = REG_ADDR_W'($urandom);
  endtask

  task automatic issue_rand(input logic [1:0] op, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b, input logic [REG_ADDR_W-1:0] d);
    issue(op, a, b, d, ref_model(op, a, b));
  endtask

  // Monitor: checks status every cycle and pops the scoreboard on each done
  always @(negedge clk) begin
    if (mon_en) begin
      exp_busy = (acc_cycle >= 0) && (cyc > acc_cycle) && (cyc <= acc_cycle + LAT);
      check("busy", {31'd0, bus.busy}, {31'd0, exp_busy});
      if (bus.done === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 wr_data=0x%0h expected no completion (cycle %0d)",
                   bus.wr_data, cyc);
        end else begin
          mon_e = sb_q.pop_front();
          check("latency",  32'(cyc),          32'(mon_e.due));
          check("wr_data",  32'(bus.wr_data),  32'(mon_e.data));
          check("wr_en",    32'(bus.wr_en),    32'(mon_e.en));
          check("wr_reg",   32'(bus.wr_reg),   32'(mon_e.rg));
          last_data = mon_e.data;
        end
      end else begin
        check("done_low",     32'(bus.done),    32'd0);
        check("wr_en_low",    32'(bus.wr_en),   32'd0);
        check("wr_reg_low",   32'(bus.wr_reg),  32'd0);
        check("wr_data_hold", 32'(bus.wr_data), 32'(last_data));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int n;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;

    // Reset with start held high: reset must win
    bus.start     = 1'b1;
    bus.op        = OP_MUL;
    bus.operand_a = 16'h0003;
    bus.operand_b = 16'h0003;
    bus.dest_reg  = 3'd1;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",    32'(bus.busy),    32'd0);
    check("rst_done",    32'(bus.done),    32'd0);
    check("rst_wr_en",   32'(bus.wr_en),   32'd0);
    check("rst_wr_reg",  32'(bus.wr_reg),  32'd0);
    check("rst_wr_data", 32'(bus.wr_data), 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    rst_n     = 1'b1;
    mon_en    = 1'b1;
    @(posedge clk); #1;

    // Directed arithmetic cases
    issue(OP_MUL,  16'h012C, 16'h01F4, 3'd3, 16'h49F0);
    issue(OP_MULH, 16'h012C, 16'h01F4, 3'd3, 16'h0002);
    issue(OP_DIV,  16'd1000, 16'd7,    3'd5, 16'h008E);
    issue(OP_REM,  16'd1000, 16'd7,    3'd5, 16'h0006);
    issue(OP_DIV,  16'h1234, 16'h0000, 3'd1, 16'hFFFF);
    issue(OP_REM,  16'h1234, 16'h0000, 3'd2, 16'h1234);

    // Start re-pulsed at T+5 with other operands must be ignored
    issue(OP_MUL, 16'h0003, 16'h0004, 3'd6, 16'h000C);
    t = acc_cycle;
    while (cyc < t + 5) begin @(posedge clk); #1; end
    bus.start     = 1'b1;
    bus.op        = OP_MUL;
    bus.operand_a = 16'h0007;
    bus.operand_b = 16'h0009;
    bus.dest_reg  = 3'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;

    // Reset for one cycle at T+8 aborts the operation
    issue(OP_DIV, 16'd100, 16'd3, 3'd4, 16'h0021);
    t = acc_cycle;
    while (cyc < t + 8) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb_q.delete();
    acc_cycle = -1;
    last_data = '0;
    while (cyc < t + 41) begin @(posedge clk); #1; end
    issue(OP_MUL, 16'h0002, 16'h0002, 3'd7, 16'h0004);

    // Destination register 0: completes without a write
    issue(OP_MUL, 16'h0005, 16'h0005, 3'd0, 16'h0019);

`ifdef MULDIV_SIGNED_EN
    issue(OP_DIV,  16'hFFF9, 16'h0002, 3'd2, 16'hFFFD);
    issue(OP_REM,  16'hFFF9, 16'h0002, 3'd2, 16'hFFFF);
    issue(OP_DIV,  16'h8000, 16'hFFFF, 3'd3, 16'h8000);
    issue(OP_REM,  16'h8000, 16'hFFFF, 3'd3, 16'h0000);
    issue(OP_MULH, 16'hFFFF, 16'h0002, 3'd4, 16'hFFFF);
    issue(OP_REM,  16'hFFF0, 16'h0000, 3'd4, 16'hFFF0);
`endif

    // Randomized ops, with boundary divisors and operands mixed in
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0:       a = 16'hFFFF;
        1:       a = 16'h8000;
        default: a = WIDTH'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       b = 16'h0000;
        1:       b = WIDTH'($urandom_range(1, 15));
        2:       b = 16'hFFFF;
        default: b = WIDTH'($urandom);
      endcase
      issue_rand(op, a, b, REG_ADDR_W'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    // Drain outstanding expectations
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending results expected 0", sb_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
